vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 100 ++++++++++
 tb/tb_vga_timing_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : 640x480@60 VGA timing generator. A 1-bit divider halves the
//                50 MHz Clock into 25 MHz pixel slots. Syncs and video_on are
//                decoded from the next counter values, so every output is
//                registered and aligned with pixel_x/pixel_y.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       Clock,
   input  logic       reset,
   output logic       Hsinc,
   output logic       Vsinc,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       pixel_tick,
   output logic       frame_tick
);

   // Last count of each axis, and inclusive sync windows.
   localparam logic [9:0] c_h_max      = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] c_v_max      = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] c_h_visible  = 10'(H_VISIBLE);
   localparam logic [9:0] c_v_visible  = 10'(V_VISIBLE);
   localparam logic [9:0] c_hs_start   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] c_hs_end     = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] c_vs_start   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] c_vs_end     = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic       r_div;
   logic [9:0] r_x;
   logic [9:0] r_y;
   logic       r_hs;
   logic       r_vs;
   logic       r_video;
   logic       r_frame;

   logic       w_adv;
   logic       w_x_end;
   logic       w_y_end;
   logic [9:0] w_x_next;
   logic [9:0] w_y_next;

   // Next-count computation; ">=" also folds any out-of-range value back to 0.
   always_comb begin
      w_adv    = r_div;
      w_x_end  = (r_x >= c_h_max);
      w_y_end  = (r_y >= c_v_max);
      w_x_next = w_x_end ? 10'd0 : (r_x + 10'd1);
      w_y_next = r_y;
      if (w_x_end) begin
         w_y_next = w_y_end ? 10'd0 : (r_y + 10'd1);
      end
   end

   // Divider, counters and output decode, all updated together on an advance.
   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         r_div   <= 1'b0;
         r_x     <= 10'd0;
         r_y     <= 10'd0;
         r_hs    <= 1'b1;
         r_vs    <= 1'b1;
         r_video <= 1'b0;
         r_frame <= 1'b0;
      end else begin
         r_div   <= ~r_div;
         r_frame <= 1'b0;
         if (w_adv) begin
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_hs    <= !((w_x_next >= c_hs_start) && (w_x_next <= c_hs_end));
            r_vs    <= !((w_y_next >= c_vs_start) && (w_y_next <= c_vs_end));
            r_video <= (w_x_next < c_h_visible) && (w_y_next < c_v_visible);
            r_frame <= w_x_end && w_y_end;
         end
      end
   end

   assign Hsinc      = r_hs;
   assign Vsinc      = r_vs;
   assign video_on   = r_video;
   assign pixel_x    = r_x;
   assign pixel_y    = r_y;
   assign pixel_tick = r_div;
   assign frame_tick = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Directed bench. One instance uses the standard 640x480
//                timing for horizontal and reset behaviour; a second instance
//                with a 12-line frame exercises vertical sync and frame wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

   logic       clk;
   logic       reset;

   logic       d_hs, d_vs, d_video, d_tick, d_frame;
   logic [9:0] d_x, d_y;
   logic       s_hs, s_vs, s_video, s_tick, s_frame;
   logic [9:0] s_x, s_y;

   int n_err    = 0;
   int n_checks = 0;

   vga_timing_gen dut (
      .Clock      (clk),
      .reset      (reset),
      .Hsinc      (d_hs),
      .Vsinc      (d_vs),
      .video_on   (d_video),
      .pixel_x    (d_x),
      .pixel_y    (d_y),
      .pixel_tick (d_tick),
      .frame_tick (d_frame)
   );

   // Small frame: lines 0..5 visible, 6..7 front porch, 8..9 sync, 10..11 back porch.
   vga_timing_gen #(
      .V_VISIBLE (6),
      .V_FRONT   (2),
      .V_SYNC    (2),
      .V_BACK    (2)
   ) dut_s (
      .Clock      (clk),
      .reset      (reset),
      .Hsinc      (s_hs),
      .Vsinc      (s_vs),
      .video_on   (s_video),
      .pixel_x    (s_x),
      .pixel_y    (s_y),
      .pixel_tick (s_tick),
      .frame_tick (s_frame)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Step negedges until the chosen instance shows (x,y); a timeout is a failure.
   task automatic wait_xy(input bit sel, input int x, input int y, input int limit, input string tag);
      int n = 0;
      while (!((sel ? int'(s_x) : int'(d_x)) == x && (sel ? int'(s_y) : int'(d_y)) == y) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(tag, (n < limit) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      int n;
      int vc;
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_x",     d_x,     0);
      check("rst_y",     d_y,     0);
      check("rst_tick",  d_tick,  0);
      check("rst_frame", d_frame, 0);
      check("rst_hs",    d_hs,    1);
      check("rst_vs",    d_vs,    1);
      check("rst_video", d_video, 0);

      // Release: first advance on the second edge, no frame pulse.
      reset = 1'b1;
      @(negedge clk);
      check("e1_tick",  d_tick,  1);
      check("e1_x",     d_x,     0);
      check("e1_video", d_video, 0);
      check("e1_frame", d_frame, 0);
      @(negedge clk);
      check("e2_x",     d_x,     1);
      check("e2_tick",  d_tick,  0);
      check("e2_video", d_video, 1);
      check("e2_frame", d_frame, 0);
      @(negedge clk);
      check("e3_tick",  d_tick,  1);
      @(negedge clk);
      check("e4_x",     d_x,     2);

      // Visible edge and horizontal sync
      wait_xy(0, 639, 0, 2000, "reach_639");
      check("vid_639", d_video, 1);
      repeat (2) @(negedge clk);
      check("x_640",     d_x,     640);
      check("vid_640",   d_video, 0);
      check("hs_640",    d_hs,    1);
      wait_xy(0, 656, 0, 200, "reach_656");
      check("hs_656", d_hs, 0);
      n = 0;
      while (d_hs == 1'b0 && n < 1000) begin
         n++;
         @(negedge clk);
      end
      check("hs_low_clocks", n,    192);
      check("hs_end_x",      d_x,  752);
      check("hs_end_level",  d_hs, 1);

      // Line period
      wait_xy(0, 0, 1, 400, "reach_line1");
      check("l1_video", d_video, 1);
      check("l1_vs",    d_vs,    1);
      n = 0;
      while (!(d_x == 10'd0 && d_y == 10'd2) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("line_clocks", n, 1600);

      // Asynchronous reset in the middle of a sync pulse
      wait_xy(0, 700, 2, 2000, "reach_700");
      check("hs_700", d_hs, 0);
      #3 reset = 1'b0;
      #1;
      check("arst_hs",   d_hs,   1);
      check("arst_x",    d_x,    0);
      check("arst_y",    d_y,    0);
      check("arst_tick", d_tick, 0);
      @(negedge clk);
      reset = 1'b1;

      // Vertical timing on the small frame
      wait_xy(1, 0, 5, 10000, "s_reach_y5");
      check("s_vid_y5", s_video, 1);
      wait_xy(1, 0, 6, 2000, "s_reach_y6");
      check("s_vid_y6", s_video, 0);
      check("s_vs_y6",  s_vs,    1);
      wait_xy(1, 0, 8, 4000, "s_reach_y8");
      check("s_vs_y8", s_vs, 0);
      n = 0;
      while (s_vs == 1'b0 && n < 5000) begin
         n++;
         @(negedge clk);
      end
      check("s_vs_low_clocks", n,    3200);
      check("s_vs_end_y",      s_y,  10);
      check("s_vs_end_level",  s_vs, 1);

      // Frame wrap from the last pixel
      wait_xy(1, 799, 11, 4000, "s_reach_last");
      check("s_last_video", s_video, 0);
      check("s_last_frame", s_frame, 0);
      check("s_last_hs",    s_hs,    1);
      repeat (2) @(negedge clk);
      check("wrap_x",     s_x,     0);
      check("wrap_y",     s_y,     0);
      check("wrap_frame", s_frame, 1);
      check("wrap_hs",    s_hs,    1);
      check("wrap_vs",    s_vs,    1);
      check("wrap_video", s_video, 1);

      // One full frame: period and visible pixel count
      n  = 0;
      vc = 0;
      do begin
         if (s_video && s_tick) vc++;
         @(negedge clk);
         n++;
         if (n == 1) check("frame_one_clock", s_frame, 0);
      end while (!s_frame && n < 25000);
      check("frame_clocks", n,  19200);
      check("visible_ticks", vc, 3840);

      // Reset during vertical sync, then time to the next sync
      wait_xy(1, 0, 8, 20000, "s_reach_y8b");
      check("s_vs_y8b", s_vs, 0);
      #3 reset = 1'b0;
      #1;
      check("s_arst_vs", s_vs, 1);
      check("s_arst_x",  s_x,  0);
      check("s_arst_y",  s_y,  0);
      @(negedge clk);
      reset = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (s_vs != 1'b0 && n < 20000);
      check("s_vs_restart_clocks", n, 12800);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
